bcd_counter_display: RTL and testbench
======================================

# bcd_counter_display

Parametrised N-digit decimal counter with a snapshot display register and per-digit 7-segment decode. It is the next generation of the fixed three-digit counting chain. It adds:
- configurable digit count
- synchronous preset and clear
- saturate/wrap mode with a sticky overflow flag
- optional down-counting

It sits between an event/enable source (prescaler, pulse detector) and the board's 7-segment displays. Its cascade output chains further instances.

## Interface
Parameters:
- DIGITS, 3, number of BCD digits (1..8); digit 0 is least significant
- SEG_INV, 0, 1 inverts all segment outputs (common-anode displays)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- en_in  in  1  count enable; one step per cycle while high
- clr  in  1  synchronous clear of count and overflow flag
- preset_load  in  1  load preset_bcd into count
- preset_bcd  in  4*DIGITS  preset value, digit i at [4i+3:4i]
- snap  in  1  capture count into display register
- mode_sat  in  1  1 = saturate at terminal value, 0 = wrap
- dir  in  1  1 = count down (present only with BCD_COUNTER_DOWN_EN)
- count_bcd  out  4*DIGITS  live count
- disp_bcd  out  4*DIGITS  display register
- seg  out  7*DIGITS  segments of disp_bcd; digit i at [7i+6:7i], bit order {a,b,c,d,e,f,g}
- en_out  out  1  cascade enable to next instance
- ovf  out  1  sticky overflow/underflow flag

## Operation
- Update priority, evaluated each clk edge:
  1. reset low: count=0, disp=0, ovf=0.
  2. clr: count=0, ovf=0.
  3. preset_load: count=preset_bcd. A preset digit >9 loads as 0.
  4. en_in: step.
  5. Otherwise hold.
- Up step: digit 0 increments; a digit at 9 rolls to 0 and carries into the next digit.
- Terminal value:
  - Up: all digits 9.
  - Down: all digits 0.
- Step at terminal, wrap mode (mode_sat=0): count goes to the opposite extreme (0…0 up, 9…9 down); ovf set.
- Step at terminal, saturate mode (mode_sat=1): count holds; ovf set.
- ovf is sticky. It is cleared only by reset or clr. preset_load does not clear it.
- snap: disp takes the count value present before this edge. snap is independent of clr, preset_load and en_in. Without snap, disp holds.
- Segment encoding, active-high when SEG_INV=0:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - Any other code: 0000000.
- en_out = en_in & terminal & ~mode_sat & ~clr & ~preset_load & reset. It is combinational from registered count and inputs, so chained instances step on the same edge as the wrap.

## Timing
- count_bcd, disp_bcd and ovf are registered.
- seg is combinational from disp_bcd, so seg shows a new value in the same cycle disp changes.
- Count-to-display latency: one snap edge.
- Reset values:
  - count_bcd=0, disp_bcd=0, ovf=0.
  - seg = DIGITS×1111110, inverted if SEG_INV.
  - en_out=0 while reset is low.
- Reset asserted mid-count takes effect at the next edge and overrides all other inputs.
- A single en_in pulse advances the count by exactly one.
- At terminal, en_out is high for exactly the cycles in which en_in is high.

## Configuration
- BCD_COUNTER_DOWN_EN defined:
  - dir port exists.
  - dir=1 decrements; digit 0 borrows 9 from the next digit.
  - Terminal value is 0…0; wrap goes to 9…9; saturate holds at 0.
  - en_out uses the terminal value for the current dir.
- Undefined:
  - No dir port; counting is up only.

## Structure
- Package bcd_counter_pkg holds:
  - BCD_W=4, SEG_W=7, DIGIT_MAX=4'd9
  - function bcd_to_seg(bcd) returning the encoding above
- Sub-module bcd_digit_cell implements one digit: register, step/wrap, carry/borrow in and out, preset/clear. The top generates DIGITS instances in a carry chain.
- The top holds the terminal detect, ovf, the display register and segment decode.

## Test plan
- Reset low with en_in=1 for 3 cycles, then release → count_bcd=000, seg=1111110×3, ovf=0, en_out=0.
- DIGITS=3, mode_sat=0, en_in held 1000 cycles from 000:
  - wraps to 000 on the 1000th edge
  - en_out high only during the cycle count=999
  - ovf=1 afterwards
- mode_sat=1, preset 998, en_in 3 cycles → count 999 and held, ovf=1, en_out=0 throughout.
- Count at 417, snap and en_in on the same edge → disp_bcd=417, count_bcd=418, seg(digit2)=0110011.
- preset_bcd=0xA5F (invalid digits) → count_bcd=050. Then preset_load and clr on the same edge → count=000, ovf=0.
- With BCD_COUNTER_DOWN_EN, dir=1, count 000, mode_sat=0, one en_in → count 999, ovf=1, en_out high during the step cycle.

Source files
------------

// File: rtl/bcd_counter_pkg.sv
// Shared widths, limits and the 7-segment decode for the BCD counter.
package bcd_counter_pkg;

  localparam int BCD_W = 4;
  localparam int SEG_W = 7;
  localparam logic [BCD_W-1:0] DIGIT_MAX = 4'd9;

  // Segment pattern {a,b,c,d,e,f,g}, active-high; non-decimal codes are blank
  function automatic logic [SEG_W-1:0] bcd_to_seg(input logic [BCD_W-1:0] bcd);
    logic [SEG_W-1:0] s;
    case (bcd)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bcd_counter_display_if.sv
// Control and display bundle of bcd_counter_display.
// The dir signal exists only when BCD_COUNTER_DOWN_EN is defined.
interface bcd_counter_display_if #(parameter int DIGITS = 3);

  logic                en_in;
  logic                clr;
  logic                preset_load;
  logic [4*DIGITS-1:0] preset_bcd;
  logic                snap;
  logic                mode_sat;
`ifdef BCD_COUNTER_DOWN_EN
  logic                dir;
`endif
  logic [4*DIGITS-1:0] count_bcd;
  logic [4*DIGITS-1:0] disp_bcd;
  logic [7*DIGITS-1:0] seg;
  logic                en_out;
  logic                ovf;

  modport master (
`ifdef BCD_COUNTER_DOWN_EN
    output dir,
`endif
    output en_in, clr, preset_load, preset_bcd, snap, mode_sat,
    input  count_bcd, disp_bcd, seg, en_out, ovf
  );

  modport slave (
`ifdef BCD_COUNTER_DOWN_EN
    input  dir,
`endif
    input  en_in, clr, preset_load, preset_bcd, snap, mode_sat,
    output count_bcd, disp_bcd, seg, en_out, ovf
  );

endinterface

// File: rtl/bcd_digit_cell.sv
// One BCD digit of the counting chain: clear, preset, and step with
// carry (up) or borrow (down) propagated to the next digit.
import bcd_counter_pkg::*;

module bcd_digit_cell (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [BCD_W-1:0] load_val,
  input  logic             step_in,
  input  logic             dir,
  output logic [BCD_W-1:0] q,
  output logic             carry_out
);

  // Digit register; invalid preset codes load as zero
  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= (load_val > DIGIT_MAX) ? '0 : load_val;
    end else if (step_in) begin
      if (dir) q <= (q == '0) ? DIGIT_MAX : q - 4'd1;
      else     q <= (q == DIGIT_MAX) ? '0 : q + 4'd1;
    end
  end

  // Carry/borrow when this digit rolls over on a step
  always_comb begin
    carry_out = step_in & (dir ? (q == '0) : (q == DIGIT_MAX));
  end

endmodule

// File: rtl/bcd_counter_display.sv
// N-digit BCD counter with snapshot display register and 7-segment decode.
// Optional down-counting is enabled by defining BCD_COUNTER_DOWN_EN.
import bcd_counter_pkg::*;

module bcd_counter_display #(
  parameter int DIGITS  = 3,
  parameter int SEG_INV = 0
) (
  input logic                  clk,
  input logic                  reset,
  bcd_counter_display_if.slave bus
);

  logic [BCD_W*DIGITS-1:0] count_w;
  logic [BCD_W*DIGITS-1:0] disp_q;
  logic [SEG_W*DIGITS-1:0] seg_w;
  logic [DIGITS:0]         carry;
  logic                    dir_w;
  logic                    terminal;
  logic                    ovf_q;

  // Direction select; up-only builds tie it low
  always_comb begin
`ifdef BCD_COUNTER_DOWN_EN
    dir_w = bus.dir;
`else
    dir_w = 1'b0;
`endif
  end

  // Terminal value is all nines counting up, all zeros counting down
  always_comb begin
    terminal = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (dir_w) terminal &= (count_w[BCD_W*i +: BCD_W] == '0);
      else       terminal &= (count_w[BCD_W*i +: BCD_W] == DIGIT_MAX);
    end
  end

  // Saturate mode suppresses the step at terminal; wrap falls out of the
  // natural carry chain (999->000 up, 000->999 down)
  always_comb begin
    carry[0] = bus.en_in & ~(terminal & bus.mode_sat);
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_cell u_cell (
      .clk       (clk),
      .reset     (reset),
      .clr       (bus.clr),
      .load      (bus.preset_load),
      .load_val  (bus.preset_bcd[BCD_W*g +: BCD_W]),
      .step_in   (carry[g]),
      .dir       (dir_w),
      .q         (count_w[BCD_W*g +: BCD_W]),
      .carry_out (carry[g+1])
    );
  end

  // Sticky overflow: set by any step attempted at terminal
  always_ff @(posedge clk) begin
    if (!reset) begin
      ovf_q <= 1'b0;
    end else if (bus.clr) begin
      ovf_q <= 1'b0;
    end else if (!bus.preset_load && bus.en_in && terminal) begin
      ovf_q <= 1'b1;
    end
  end

  // Display snapshot of the pre-edge count
  always_ff @(posedge clk) begin
    if (!reset) begin
      disp_q <= '0;
    end else if (bus.snap) begin
      disp_q <= count_w;
    end
  end

  // Segment decode of the display register, optionally inverted
  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      seg_w[SEG_W*i +: SEG_W] = (SEG_INV != 0) ? ~bcd_to_seg(disp_q[BCD_W*i +: BCD_W])
                                               :  bcd_to_seg(disp_q[BCD_W*i +: BCD_W]);
    end
  end

  // Cascade enable lines up with this instance's wrap edge
  always_comb begin
    bus.en_out = bus.en_in & terminal & ~bus.mode_sat & ~bus.clr
               & ~bus.preset_load & reset;
  end

  assign bus.count_bcd = count_w;
  assign bus.disp_bcd  = disp_q;
  assign bus.seg       = seg_w;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_bcd_counter_display.sv
// Bench for bcd_counter_display (DIGITS=3): integer-valued reference model
// checked every cycle, plus literal expectations for the directed scenarios.
module tb_bcd_counter_display;

  localparam int D    = 3;
  localparam int MAXV = 999;

  logic clk = 1'b0;
  logic reset;
  bcd_counter_display_if #(.DIGITS(D)) bus();

  bcd_counter_display #(.DIGITS(D), .SEG_INV(0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int m_count   = 0;
  int m_disp    = 0;
  bit m_ovf     = 1'b0;
  bit check_en  = 1'b0;
  int enout_hi  = 0;

  logic [6:0] seg_tab [10];
  initial begin
    seg_tab[0] = 7'b1111110; seg_tab[1] = 7'b0110000; seg_tab[2] = 7'b1101101;
    seg_tab[3] = 7'b1111001; seg_tab[4] = 7'b0110011; seg_tab[5] = 7'b1011011;
    seg_tab[6] = 7'b1011111; seg_tab[7] = 7'b1110000; seg_tab[8] = 7'b1111111;
    seg_tab[9] = 7'b1111011;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [4*D-1:0] to_bcd(input int v);
    logic [4*D-1:0] r;
    int t;
    t = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [7*D-1:0] to_seg(input int v);
    logic [7*D-1:0] r;
    int t;
    t = v;
    for (int i = 0; i < D; i++) begin
      r[7*i +: 7] = seg_tab[t % 10];
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int preset_val(input logic [4*D-1:0] p);
    int v, w;
    v = 0; w = 1;
    for (int i = 0; i < D; i++) begin
      if (p[4*i +: 4] <= 4'd9) v += int'(p[4*i +: 4]) * w;
      w *= 10;
    end
    return v;
  endfunction

  function automatic bit cur_dir();
`ifdef BCD_COUNTER_DOWN_EN
    return bus.dir;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit at_term();
    return cur_dir() ? (m_count == 0) : (m_count == MAXV);
  endfunction

  // Reference model: advance on each rising edge from pre-edge inputs
  always @(posedge clk) begin
    if (!reset) begin
      m_count = 0; m_disp = 0; m_ovf = 1'b0;
    end else begin
      if (bus.snap) m_disp = m_count;
      if (bus.clr) begin
        m_count = 0; m_ovf = 1'b0;
      end else if (bus.preset_load) begin
        m_count = preset_val(bus.preset_bcd);
      end else if (bus.en_in) begin
        if (at_term()) begin
          m_ovf = 1'b1;
          if (!bus.mode_sat) m_count = cur_dir() ? MAXV : 0;
        end else begin
          m_count = cur_dir() ? m_count - 1 : m_count + 1;
        end
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (check_en) begin
      chk("count_bcd", 32'(bus.count_bcd), 32'(to_bcd(m_count)));
      chk("disp_bcd",  32'(bus.disp_bcd),  32'(to_bcd(m_disp)));
      chk("seg",       32'(bus.seg),       32'(to_seg(m_disp)));
      chk("ovf",       32'(bus.ovf),       32'(m_ovf));
      chk("en_out",    32'(bus.en_out),
          32'(reset & bus.en_in & at_term() & ~bus.mode_sat & ~bus.clr & ~bus.preset_load));
      if (bus.en_out === 1'b1) enout_hi++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    bus.en_in = 1'b1; bus.clr = 1'b0; bus.preset_load = 1'b0;
    bus.preset_bcd = '0; bus.snap = 1'b0; bus.mode_sat = 1'b0;
`ifdef BCD_COUNTER_DOWN_EN
    bus.dir = 1'b0;
`endif
    tick();
    check_en = 1'b1;
    tick(); tick();
    chk("rst_en_out", 32'(bus.en_out), 32'd0);
    reset = 1'b1; bus.en_in = 1'b0;
    chk("rst_count", 32'(bus.count_bcd), 32'h000);
    chk("rst_seg",   32'(bus.seg), 32'({7'b1111110, 7'b1111110, 7'b1111110}));
    chk("rst_ovf",   32'(bus.ovf), 32'd0);
    tick();

    // Wrap run: 1000 steps from 000
    enout_hi = 0;
    bus.en_in = 1'b1;
    for (int i = 0; i < 1000; i++) tick();
    bus.en_in = 1'b0;
    chk("wrap_count", 32'(bus.count_bcd), 32'h000);
    chk("wrap_ovf",   32'(bus.ovf), 32'd1);
    tick();
    chk("wrap_enout_cycles", 32'(enout_hi), 32'd1);

    // Saturate from 998 (ovf cleared first)
    bus.clr = 1'b1; tick(); bus.clr = 1'b0;
    chk("clr_ovf", 32'(bus.ovf), 32'd0);
    enout_hi = 0;
    bus.mode_sat = 1'b1;
    bus.preset_bcd = 12'h998; bus.preset_load = 1'b1; tick(); bus.preset_load = 1'b0;
    bus.en_in = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    bus.en_in = 1'b0;
    chk("sat_count", 32'(bus.count_bcd), 32'h999);
    chk("sat_ovf",   32'(bus.ovf), 32'd1);
    chk("sat_enout_cycles", 32'(enout_hi), 32'd0);
    bus.mode_sat = 1'b0;
    tick();

    // Invalid preset digits; preset keeps ovf; clr wins over preset
    bus.preset_bcd = 12'hA5F; bus.preset_load = 1'b1; tick(); bus.preset_load = 1'b0;
    chk("inv_preset", 32'(bus.count_bcd), 32'h050);
    chk("preset_keeps_ovf", 32'(bus.ovf), 32'd1);
    bus.preset_bcd = 12'h321; bus.preset_load = 1'b1; bus.clr = 1'b1; tick();
    bus.preset_load = 1'b0; bus.clr = 1'b0;
    chk("clr_prio_count", 32'(bus.count_bcd), 32'h000);
    chk("clr_prio_ovf",   32'(bus.ovf), 32'd0);

    // Snap and step on the same edge at 417
    bus.preset_bcd = 12'h417; bus.preset_load = 1'b1; tick(); bus.preset_load = 1'b0;
    bus.snap = 1'b1; bus.en_in = 1'b1; tick(); bus.snap = 1'b0; bus.en_in = 1'b0;
    chk("snap_disp",  32'(bus.disp_bcd), 32'h417);
    chk("snap_count", 32'(bus.count_bcd), 32'h418);
    chk("snap_seg2",  32'(bus.seg[20:14]), 32'(7'b0110011));
    tick(); tick();
    chk("disp_hold",  32'(bus.disp_bcd), 32'h417);

    // Mid-count reset overrides everything
    bus.en_in = 1'b1; bus.snap = 1'b1; reset = 1'b0; tick();
    chk("midrst_count", 32'(bus.count_bcd), 32'h000);
    chk("midrst_disp",  32'(bus.disp_bcd), 32'h000);
    reset = 1'b1; bus.en_in = 1'b0; bus.snap = 1'b0; tick();

`ifdef BCD_COUNTER_DOWN_EN
    // Down wrap from 000
    bus.dir = 1'b1; bus.clr = 1'b1; tick(); bus.clr = 1'b0;
    bus.en_in = 1'b1;
    #1 chk("down_enout", 32'(bus.en_out), 32'd1);
    tick(); bus.en_in = 1'b0;
    chk("down_count", 32'(bus.count_bcd), 32'h999);
    chk("down_ovf",   32'(bus.ovf), 32'd1);
    bus.en_in = 1'b1; tick(); bus.en_in = 1'b0;
    chk("down_step",  32'(bus.count_bcd), 32'h998);
    bus.dir = 1'b0;
    tick();
`endif

    check_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
